// File: rtl/mem_arbiter_pkg.sv
// Shared types and helpers for the byte-serial memory bus arbiter.
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        MaIdle,
        MaIfetch,
        MaDread,
        MaDwrite
    } ma_state_e;

    typedef enum logic {
        GrantIc,
        GrantLs
    } grant_e;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;

    // Size code 11 falls through to a word access.
    function automatic logic [2:0] size_bytes(input logic [1:0] size);
        case (size)
            SZ_B:    return 3'd1;
            SZ_H:    return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

    function automatic logic is_io(input logic [1:0] addr_hi, input logic [1:0] io_hi);
        return addr_hi == io_hi;
    endfunction

endpackage

// File: rtl/mem_arbiter.sv
// Shares the byte-wide RAM/IO bus between ICache line fills and the load/store buffer,
// serialising multi-byte accesses and hiding the one-cycle RAM read latency.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned ILINE_BYTES = 4,
    parameter logic [1:0]  IO_HI       = 2'b11
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     rdy,
    input  logic                     jp_wrong,
    input  logic                     ic_req,
    input  logic [31:0]              ic_addr,
    output logic                     ic_done,
    output logic [ILINE_BYTES*8-1:0] ic_data,
    input  logic                     ls_req,
    input  logic                     ls_we,
    input  logic [31:0]              ls_addr,
    input  logic [1:0]               ls_size,
    input  logic [31:0]              ls_wdata,
    output logic                     ls_done,
    output logic [31:0]              ls_rdata,
    input  logic                     io_buffer_full,
    input  logic [7:0]               mem_din,
    output logic [7:0]               mem_dout,
    output logic [31:0]              mem_a,
    output logic                     mem_wr
);

    localparam int unsigned CW = $clog2(ILINE_BYTES) + 1;
    localparam int unsigned LW = ILINE_BYTES * 8;

    ma_state_e     state_q, state_d;
    grant_e        last_q, last_d;
    logic [CW-1:0] rcnt_q, rcnt_d, wcnt_q, wcnt_d, nbytes_q, nbytes_d, rcnt_next;
    logic [31:0]   base_q, base_d, a_q, a_d, wdata_q, wdata_d;
    logic [LW-1:0] line_q, line_d;
    // The address driven last cycle was issued with rdy high and belongs to byte rcnt_q.
    logic          pend_q, pend_d;
    logic          pick_ic, pick_ls, more;

    always_comb begin
        state_d   = state_q;
        last_d    = last_q;
        rcnt_d    = rcnt_q;
        wcnt_d    = wcnt_q;
        nbytes_d  = nbytes_q;
        base_d    = base_q;
        wdata_d   = wdata_q;
        line_d    = line_q;
        pend_d    = pend_q;
        a_d       = a_q;
        rcnt_next = rcnt_q;
        more      = 1'b0;
        pick_ic   = 1'b0;
        pick_ls   = 1'b0;
        mem_dout  = 8'h00;
        mem_wr    = 1'b0;
        ic_done   = 1'b0;
        ls_done   = 1'b0;

        unique case (state_q)
            MaIdle: begin
                pend_d = 1'b0;
                // Grant is combinational so the first byte issues in the grant cycle itself.
                if (rst_n && rdy && !jp_wrong) begin
                    pick_ls = ls_req && (!ic_req || last_q == GrantIc);
                    pick_ic = ic_req && !pick_ls;
                end
                if (pick_ic) begin
                    state_d  = MaIfetch;
                    last_d   = GrantIc;
                    base_d   = ic_addr;
                    nbytes_d = CW'(ILINE_BYTES);
                    rcnt_d   = '0;
                    line_d   = '0;
                    a_d      = ic_addr;
                    pend_d   = 1'b1;
                end else if (pick_ls) begin
                    last_d   = GrantLs;
                    base_d   = ls_addr;
                    nbytes_d = CW'(size_bytes(ls_size));
                    rcnt_d   = '0;
                    wcnt_d   = '0;
                    line_d   = '0;
                    a_d      = ls_addr;
                    if (ls_we) begin
                        state_d = MaDwrite;
                        wdata_d = ls_wdata;
                        if (!(is_io(ls_addr[17:16], IO_HI) && io_buffer_full)) begin
                            mem_wr   = 1'b1;
                            mem_dout = ls_wdata[7:0];
                            wcnt_d   = CW'(1);
                        end
                    end else begin
                        state_d = MaDread;
                        pend_d  = 1'b1;
                    end
                end
            end

            MaIfetch, MaDread: begin
                if (!rdy) begin
                    // Data returned during a stall is not trusted; re-present and retry.
                    pend_d = 1'b0;
                    if (rcnt_q != nbytes_q) a_d = base_q + 32'(rcnt_q);
                end else if (jp_wrong) begin
                    state_d = MaIdle;
                    pend_d  = 1'b0;
                end else if (rcnt_q == nbytes_q) begin
                    ic_done = (state_q == MaIfetch);
                    ls_done = (state_q == MaDread);
                    state_d = MaIdle;
                end else begin
                    if (pend_q) begin
                        line_d[8*int'(rcnt_q) +: 8] = mem_din;
                        rcnt_next = rcnt_q + 1'b1;
                    end
                    rcnt_d = rcnt_next;
                    more   = (rcnt_next != nbytes_q);
                    pend_d = more;
                    if (more) a_d = base_q + 32'(rcnt_next);
                end
            end

            MaDwrite: begin
                if (wcnt_q == nbytes_q) begin
                    if (rdy) begin
                        ls_done = 1'b1;
                        state_d = MaIdle;
                    end
                end else begin
                    a_d = base_q + 32'(wcnt_q);
                    if (rdy && !(is_io(base_q[17:16], IO_HI) && io_buffer_full)) begin
                        mem_wr   = 1'b1;
                        mem_dout = wdata_q[8*int'(wcnt_q[1:0]) +: 8];
                        wcnt_d   = wcnt_q + 1'b1;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= MaIdle;
            last_q   <= GrantIc;
            rcnt_q   <= '0;
            wcnt_q   <= '0;
            nbytes_q <= '0;
            base_q   <= '0;
            wdata_q  <= '0;
            line_q   <= '0;
            pend_q   <= 1'b0;
            a_q      <= '0;
        end else begin
            state_q  <= state_d;
            last_q   <= last_d;
            rcnt_q   <= rcnt_d;
            wcnt_q   <= wcnt_d;
            nbytes_q <= nbytes_d;
            base_q   <= base_d;
            wdata_q  <= wdata_d;
            line_q   <= line_d;
            pend_q   <= pend_d;
            a_q      <= a_d;
        end
    end

    assign mem_a    = a_d;
    assign ic_data  = line_q;
    assign ls_rdata = line_q[31:0];

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter with a one-cycle-latency RAM model.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n, rdy, jp_wrong, ic_req, ls_req, ls_we, io_buffer_full;
    logic        ic_done, ls_done, mem_wr;
    logic [31:0] ic_addr, ls_addr, ls_wdata, ls_rdata, mem_a, ic_data;
    logic [1:0]  ls_size;
    logic [7:0]  mem_din, mem_dout;

    logic [7:0]  ram [0:4095];
    int          checks = 0;
    int          errors = 0;

    logic [31:0] tr_a    [0:15];
    logic [7:0]  tr_dout [0:15];
    logic        tr_wr   [0:15];
    logic        tr_icd  [0:15];
    logic        tr_lsd  [0:15];
    logic [31:0] tr_rd   [0:15];
    logic [31:0] tr_ic   [0:15];

    mem_arbiter #(.ILINE_BYTES(4), .IO_HI(2'b11)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .rdy            (rdy),
        .jp_wrong       (jp_wrong),
        .ic_req         (ic_req),
        .ic_addr        (ic_addr),
        .ic_done        (ic_done),
        .ic_data        (ic_data),
        .ls_req         (ls_req),
        .ls_we          (ls_we),
        .ls_addr        (ls_addr),
        .ls_size        (ls_size),
        .ls_wdata       (ls_wdata),
        .ls_done        (ls_done),
        .ls_rdata       (ls_rdata),
        .io_buffer_full (io_buffer_full),
        .mem_din        (mem_din),
        .mem_dout       (mem_dout),
        .mem_a          (mem_a),
        .mem_wr         (mem_wr)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        mem_din <= ram[mem_a[11:0]];
        if (mem_wr && mem_a < 32'h1000) ram[mem_a[11:0]] <= mem_dout;
    end

    // Record cycle c (inputs already driven), then advance to just after the next edge.
    task automatic tick_rec(input int c);
        #2;
        tr_a[c]    = mem_a;
        tr_dout[c] = mem_dout;
        tr_wr[c]   = mem_wr;
        tr_icd[c]  = ic_done;
        tr_lsd[c]  = ls_done;
        tr_rd[c]   = ls_rdata;
        tr_ic[c]   = ic_data;
        @(posedge clk);
        #1;
        if (tr_icd[c]) ic_req = 1'b0;
        if (tr_lsd[c]) ls_req = 1'b0;
    endtask

    function automatic int first_ic(input int n);
        for (int i = 0; i < n; i++) if (tr_icd[i]) return i;
        return -1;
    endfunction

    function automatic int first_ls(input int n);
        for (int i = 0; i < n; i++) if (tr_lsd[i]) return i;
        return -1;
    endfunction

    task automatic do_reset();
        rst_n = 1'b0; rdy = 1'b1; jp_wrong = 1'b0; ic_req = 1'b0; ls_req = 1'b0;
        ls_we = 1'b0; io_buffer_full = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; rdy = 1'b1; jp_wrong = 1'b0; ic_req = 1'b0; ls_req = 1'b0;
        ls_we = 1'b0; io_buffer_full = 1'b0; ic_addr = '0; ls_addr = '0; ls_size = '0;
        ls_wdata = '0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (mem_a !== 32'h0 || mem_wr !== 1'b0 || mem_dout !== 8'h0) begin
            errors++;
            $display("FAIL reset_bus got a=%h wr=%b dout=%h want 0 0 0", mem_a, mem_wr, mem_dout);
        end
        checks++;
        if (ic_done !== 1'b0 || ls_done !== 1'b0 || ic_data !== 32'h0 || ls_rdata !== 32'h0) begin
            errors++;
            $display("FAIL reset_resp got icd=%b lsd=%b icdata=%h rdata=%h want all 0",
                     ic_done, ls_done, ic_data, ls_rdata);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_word_load();
        ls_req = 1'b1; ls_we = 1'b0; ls_addr = 32'h100; ls_size = 2'b10;
        for (int c = 0; c < 10; c++) tick_rec(c);
        for (int c = 0; c < 4; c++) begin
            checks++;
            if (tr_a[c] !== 32'h100 + 32'(c)) begin
                errors++;
                $display("FAIL word_load mem_a[%0d] got %h want %h", c, tr_a[c], 32'h100 + 32'(c));
            end
        end
        checks++;
        if (first_ls(10) != 5) begin
            errors++;
            $display("FAIL word_load done_cycle got %0d want 5", first_ls(10));
        end
        checks++;
        if (tr_rd[5] !== 32'h44332211) begin
            errors++;
            $display("FAIL word_load rdata got %h want 44332211", tr_rd[5]);
        end
    endtask

    task automatic test_arb();
        int nwr;
        do_reset();
        ic_req = 1'b1; ic_addr = 32'h0;
        ls_req = 1'b1; ls_we = 1'b1; ls_addr = 32'h20; ls_size = 2'b00; ls_wdata = 32'h000000AB;
        for (int c = 0; c < 12; c++) tick_rec(c);
        checks++;
        if (tr_wr[0] !== 1'b1 || tr_a[0] !== 32'h20 || tr_dout[0] !== 8'hAB) begin
            errors++;
            $display("FAIL arb_ls_first got wr=%b a=%h dout=%h want 1 00000020 ab",
                     tr_wr[0], tr_a[0], tr_dout[0]);
        end
        nwr = 0;
        for (int c = 0; c < 12; c++) if (tr_wr[c]) nwr++;
        checks++;
        if (nwr != 1) begin
            errors++;
            $display("FAIL arb_write_count got %0d want 1", nwr);
        end
        checks++;
        if (first_ls(12) != 1) begin
            errors++;
            $display("FAIL arb_ls_done got %0d want 1", first_ls(12));
        end
        checks++;
        if (tr_a[2] !== 32'h0 || tr_a[5] !== 32'h3) begin
            errors++;
            $display("FAIL arb_ic_issue got a2=%h a5=%h want 0 3", tr_a[2], tr_a[5]);
        end
        checks++;
        if (first_ic(12) != 7) begin
            errors++;
            $display("FAIL arb_ic_done got %0d want 7", first_ic(12));
        end
        checks++;
        if (tr_ic[7] !== 32'hA3A2A1A0) begin
            errors++;
            $display("FAIL arb_ic_data got %h want a3a2a1a0", tr_ic[7]);
        end
    endtask

    task automatic test_flush();
        int npulse, nwr;
        ic_req = 1'b1; ic_addr = 32'h0;
        for (int c = 0; c < 12; c++) begin
            jp_wrong = (c == 2);
            if (c == 2) ic_addr = 32'h40;
            tick_rec(c);
        end
        npulse = 0; nwr = 0;
        for (int c = 0; c < 12; c++) begin
            if (tr_icd[c]) npulse++;
            if (tr_wr[c]) nwr++;
        end
        checks++;
        if (npulse != 1 || first_ic(12) != 8) begin
            errors++;
            $display("FAIL flush_done got pulses=%0d first=%0d want 1 8", npulse, first_ic(12));
        end
        checks++;
        if (nwr != 0) begin
            errors++;
            $display("FAIL flush_no_write got %0d want 0", nwr);
        end
        checks++;
        if (tr_a[3] !== 32'h40 || tr_a[6] !== 32'h43) begin
            errors++;
            $display("FAIL flush_refetch got a3=%h a6=%h want 40 43", tr_a[3], tr_a[6]);
        end
        checks++;
        if (tr_ic[8] !== 32'hC3C2C1C0) begin
            errors++;
            $display("FAIL flush_data got %h want c3c2c1c0", tr_ic[8]);
        end
    endtask

    task automatic test_rdy_stall();
        logic [31:0] exp_a [0:6];
        exp_a = '{32'h100, 32'h101, 32'h101, 32'h101, 32'h101, 32'h102, 32'h103};
        ls_req = 1'b1; ls_we = 1'b0; ls_addr = 32'h100; ls_size = 2'b10;
        for (int c = 0; c < 12; c++) begin
            rdy = !(c == 2 || c == 3);
            tick_rec(c);
        end
        rdy = 1'b1;
        for (int c = 0; c < 7; c++) begin
            checks++;
            if (tr_a[c] !== exp_a[c]) begin
                errors++;
                $display("FAIL stall mem_a[%0d] got %h want %h", c, tr_a[c], exp_a[c]);
            end
        end
        checks++;
        if (first_ls(12) != 8) begin
            errors++;
            $display("FAIL stall_done got %0d want 8", first_ls(12));
        end
        checks++;
        if (tr_rd[8] !== 32'h44332211) begin
            errors++;
            $display("FAIL stall_rdata got %h want 44332211", tr_rd[8]);
        end
    endtask

    task automatic test_io_store();
        logic       exp_wr [0:7];
        logic [7:0] exp_d  [0:7];
        logic [31:0] exp_a [0:7];
        exp_wr = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        exp_d  = '{8'hEF, 8'h00, 8'h00, 8'h00, 8'hBE, 8'hAD, 8'hDE, 8'h00};
        exp_a  = '{32'h30000, 32'h0, 32'h0, 32'h0, 32'h30001, 32'h30002, 32'h30003, 32'h0};
        ls_req = 1'b1; ls_we = 1'b1; ls_addr = 32'h30000; ls_size = 2'b10;
        ls_wdata = 32'hDEADBEEF;
        for (int c = 0; c < 10; c++) begin
            io_buffer_full = (c >= 1 && c <= 3);
            tick_rec(c);
        end
        io_buffer_full = 1'b0;
        for (int c = 0; c < 8; c++) begin
            checks++;
            if (tr_wr[c] !== exp_wr[c] ||
                (exp_wr[c] && (tr_dout[c] !== exp_d[c] || tr_a[c] !== exp_a[c]))) begin
                errors++;
                $display("FAIL io_store[%0d] got wr=%b a=%h d=%h want wr=%b a=%h d=%h",
                         c, tr_wr[c], tr_a[c], tr_dout[c], exp_wr[c], exp_a[c], exp_d[c]);
            end
        end
        checks++;
        if (first_ls(10) != 7) begin
            errors++;
            $display("FAIL io_store_done got %0d want 7", first_ls(10));
        end
    endtask

    task automatic test_reset_mid();
        int npulse;
        ic_req = 1'b1; ic_addr = 32'h0;
        tick_rec(0);
        tick_rec(1);
        rst_n = 1'b0;
        #1;
        checks++;
        if (mem_a !== 32'h0 || mem_wr !== 1'b0 || ic_done !== 1'b0 || ic_data !== 32'h0) begin
            errors++;
            $display("FAIL reset_mid_async got a=%h wr=%b icd=%b data=%h want 0 0 0 0",
                     mem_a, mem_wr, ic_done, ic_data);
        end
        @(posedge clk);
        #1;
        checks++;
        if (mem_a !== 32'h0) begin
            errors++;
            $display("FAIL reset_mid_hold got a=%h want 0", mem_a);
        end
        ic_req = 1'b0;
        rst_n = 1'b1;
        for (int c = 0; c < 8; c++) tick_rec(c);
        npulse = 0;
        for (int c = 0; c < 8; c++) if (tr_icd[c]) npulse++;
        checks++;
        if (npulse != 0) begin
            errors++;
            $display("FAIL reset_mid_no_done got %0d pulses want 0", npulse);
        end
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) ram[i] = 8'h00;
        ram[32'h100] = 8'h11; ram[32'h101] = 8'h22; ram[32'h102] = 8'h33; ram[32'h103] = 8'h44;
        ram[0] = 8'hA0; ram[1] = 8'hA1; ram[2] = 8'hA2; ram[3] = 8'hA3;
        ram[32'h40] = 8'hC0; ram[32'h41] = 8'hC1; ram[32'h42] = 8'hC2; ram[32'h43] = 8'hC3;
        test_reset();
        test_word_load();
        test_arb();
        test_flush();
        test_rdy_stall();
        test_io_store();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
